// File: rtl/dro_array_pkg.sv
// Shared types and helpers for the DRO storage array.
// Count width derivation and toggle-encoded pulse detection.
package dro_array_pkg;

    typedef int unsigned dro_width_t;

    // Bits needed to hold a stored-pulse count of 0..depth.
    function automatic dro_width_t calc_cw(input dro_width_t depth);
        return dro_width_t'($clog2(depth + 1));
    endfunction

    // A toggle-encoded line carries one pulse per transition.
    function automatic logic toggle_detect(input logic cur, input logic hist);
        return cur ^ hist;
    endfunction

endpackage

// File: rtl/dro_cell.sv
// One destructive-readout channel: pulse counter, hold-window checker,
// read-to-output delay line and sticky violation/overflow flags.
module dro_cell
    import dro_array_pkg::*;
#(
    parameter int         DEPTH       = 1,
    parameter int         OUT_DELAY   = 2,
    parameter int         HOLD_CYCLES = 2,
    parameter dro_width_t CW          = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          set_i,
    input  logic          read_i,
    output logic          out_o,
    output logic [CW-1:0] count_o,
    output logic          viol_o,
    output logic          ovf_o
);

    localparam int             HW      = $clog2(HOLD_CYCLES + 2);
    localparam logic [HW-1:0]  HOLD_C  = HW'(HOLD_CYCLES);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam int             DLW     = (OUT_DELAY > 1) ? OUT_DELAY - 1 : 1;

    logic           set_h_q, read_h_q;
    logic [CW-1:0]  count_q, count_d;
    logic [HW-1:0]  since_set_q, since_set_d;
    logic [HW-1:0]  since_rd_q, since_rd_d;
    logic [DLW-1:0] dl_q, dl_d;
    logic           out_q, out_d;
    logic           viol_q, viol_d;
    logic           ovf_q, ovf_d;
    logic           set_ev, rd_ev, rd_ok;

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        return (v >= HOLD_C) ? HOLD_C : v + 1'b1;
    endfunction

    always_comb begin
        set_ev      = en_i & toggle_detect(set_i, set_h_q);
        rd_ev       = en_i & toggle_detect(read_i, read_h_q);
        rd_ok       = rd_ev && (count_q != '0);
        count_d     = count_q;
        viol_d      = viol_q;
        ovf_d       = ovf_q;
        // Read is applied before set so a coincident pair on a full cell is legal.
        if (rd_ok) begin
            count_d = count_q - 1'b1;
        end
        if (set_ev) begin
            if (count_d < DEPTH_C) begin
                count_d = count_d + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // Counters hold edges elapsed since the last event, saturating at the window.
        since_set_d = set_ev ? sat_inc('0) : sat_inc(since_set_q);
        since_rd_d  = rd_ev  ? sat_inc('0) : sat_inc(since_rd_q);
        if (HOLD_CYCLES > 0) begin
            if (rd_ev && (set_ev || (since_set_q < HOLD_C))) begin
                viol_d = 1'b1;
            end
            if (set_ev && (since_rd_q < HOLD_C)) begin
                viol_d = 1'b1;
            end
        end

        dl_d[0] = rd_ok;
        for (int k = 1; k < DLW; k++) begin
            dl_d[k] = dl_q[k-1];
        end
        out_d = out_q ^ ((OUT_DELAY == 1) ? rd_ok : dl_q[DLW-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            set_h_q     <= 1'b0;
            read_h_q    <= 1'b0;
            count_q     <= '0;
            since_set_q <= HOLD_C;
            since_rd_q  <= HOLD_C;
            dl_q        <= '0;
            out_q       <= 1'b0;
            viol_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            set_h_q     <= set_i;
            read_h_q    <= read_i;
            count_q     <= count_d;
            since_set_q <= since_set_d;
            since_rd_q  <= since_rd_d;
            dl_q        <= dl_d;
            out_q       <= out_d;
            viol_q      <= viol_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_o   = out_q;
    assign count_o = count_q;
    assign viol_o  = viol_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/dro_array.sv
// Multi-channel DRO storage array for SFQ behavioural co-simulation.
// Holds the post-reset init window and packs per-channel cell outputs.
module dro_array
    import dro_array_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DEPTH       = 1,
    parameter int OUT_DELAY   = 2,
    parameter int HOLD_CYCLES = 2,
    parameter int INIT_CYCLES = 8,
    localparam dro_width_t CW = calc_cw(dro_width_t'(DEPTH))
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CHANNELS-1:0]    set,
    input  logic [CHANNELS-1:0]    read,
    output logic [CHANNELS-1:0]    out,
    output logic [CHANNELS*CW-1:0] count,
    output logic [CHANNELS-1:0]    viol,
    output logic [CHANNELS-1:0]    ovf,
    output logic                   ready
);

    localparam int            IW      = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam logic [IW-1:0] INIT_C  = IW'(INIT_CYCLES);
    localparam logic          NO_INIT = (INIT_CYCLES == 0);

    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic          ready_q, ready_d;
    logic          en;

    always_comb begin
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        if (!ready_q) begin
            if (NO_INIT) begin
                ready_d = 1'b1;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_d == INIT_C) begin
                    ready_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
        end
    end

    // Events seen on the edge that raises ready are still inside the window.
    assign en    = ready_q | NO_INIT;
    assign ready = ready_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_cell
        dro_cell #(
            .DEPTH       (DEPTH),
            .OUT_DELAY   (OUT_DELAY),
            .HOLD_CYCLES (HOLD_CYCLES),
            .CW          (CW)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en),
            .set_i   (set[ch]),
            .read_i  (read[ch]),
            .out_o   (out[ch]),
            .count_o (count[ch*CW +: CW]),
            .viol_o  (viol[ch]),
            .ovf_o   (ovf[ch])
        );
    end

endmodule

// File: tb/tb_dro_array.sv
// Directed bench for dro_array: a default-parameter instance and a
// DEPTH=3 / OUT_DELAY=4 instance driven side by side.
module tb_dro_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] set_a, read_a, out_a, count_a, viol_a, ovf_a;
    logic       ready_a;
    logic [1:0] set_b, read_b, out_b, viol_b, ovf_b;
    logic [3:0] count_b;
    logic       ready_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dro_array dut_a (
        .clk   (clk),
        .rst   (rst),
        .set   (set_a),
        .read  (read_a),
        .out   (out_a),
        .count (count_a),
        .viol  (viol_a),
        .ovf   (ovf_a),
        .ready (ready_a)
    );

    dro_array #(
        .CHANNELS    (2),
        .DEPTH       (3),
        .OUT_DELAY   (4),
        .HOLD_CYCLES (2),
        .INIT_CYCLES (8)
    ) dut_b (
        .clk   (clk),
        .rst   (rst),
        .set   (set_b),
        .read  (read_b),
        .out   (out_b),
        .count (count_b),
        .viol  (viol_b),
        .ovf   (ovf_b),
        .ready (ready_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_b(input int ch);
        return 32'(count_b[ch*2 +: 2]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_a  = '0;
        read_a = '0;
        set_b  = '0;
        read_b = '0;
        rst    = 1'b1;
        tick(2);
        check("rst_out_a",   32'(out_a),   0);
        check("rst_count_a", 32'(count_a), 0);
        check("rst_viol_a",  32'(viol_a),  0);
        check("rst_ovf_a",   32'(ovf_a),   0);
        check("rst_ready_a", 32'(ready_a), 0);
        check("rst_count_b", 32'(count_b), 0);
        check("rst_out_b",   32'(out_b),   0);
        rst = 1'b0;

        // Init gate: pulse at edge 3 is swallowed, ready at edge 8
        tick(2);
        set_a[1] = ~set_a[1];
        tick(1);
        check("init_cnt1", 32'(count_a[1]), 0);
        tick(4);
        check("init_ready_e7", 32'(ready_a), 0);
        tick(1);
        check("init_ready_e8", 32'(ready_a), 1);
        check("init_ready_b",  32'(ready_b), 1);
        check("init_cnt1_after", 32'(count_a[1]), 0);

        // Default set then read five edges later
        set_a[0] = ~set_a[0];
        tick(1);
        check("dflt_cnt_set", 32'(count_a[0]), 1);
        tick(4);
        read_a[0] = ~read_a[0];
        tick(1);
        check("dflt_cnt_read", 32'(count_a[0]), 0);
        check("dflt_out_early", 32'(out_a[0]), 0);
        tick(1);
        check("dflt_out", 32'(out_a[0]), 1);
        check("dflt_viol", 32'(viol_a[0]), 0);

        // Hold window: read on the edge after set
        set_a[2] = ~set_a[2];
        tick(1);
        check("hold_cnt_set", 32'(count_a[2]), 1);
        check("hold_viol_pre", 32'(viol_a[2]), 0);
        read_a[2] = ~read_a[2];
        tick(1);
        check("hold_cnt_read", 32'(count_a[2]), 0);
        check("hold_viol", 32'(viol_a[2]), 1);
        tick(1);
        check("hold_out", 32'(out_a[2]), 1);

        // Simultaneous set and read on an empty cell
        set_a[3]  = ~set_a[3];
        read_a[3] = ~read_a[3];
        tick(1);
        check("simul_cnt", 32'(count_a[3]), 1);
        check("simul_viol", 32'(viol_a[3]), 1);
        tick(2);
        check("simul_out", 32'(out_a[3]), 0);

        // Overflow with DEPTH=1
        set_a[0] = ~set_a[0];
        tick(4);
        set_a[0] = ~set_a[0];
        tick(1);
        check("ovf_cnt", 32'(count_a[0]), 1);
        check("ovf_flags_a", 32'(ovf_a), 32'h1);
        check("viol_flags_a", 32'(viol_a), 32'hC);

        // DEPTH=3: four sets four edges apart
        for (int i = 0; i < 4; i++) begin
            set_b[0] = ~set_b[0];
            tick(1);
            check("d3_set_cnt", cnt_b(0), (i < 3) ? i + 1 : 3);
            check("d3_set_ovf", 32'(ovf_b[0]), (i == 3) ? 1 : 0);
            tick(3);
        end
        // Four reads, only three produce output toggles
        for (int i = 0; i < 4; i++) begin
            read_b[0] = ~read_b[0];
            tick(1);
            check("d3_rd_cnt", cnt_b(0), (i < 3) ? 2 - i : 0);
            tick(3);
            check("d3_rd_out", 32'(out_b[0]), (i < 3) ? ((i + 1) % 2) : 1);
        end
        check("d3_viol", 32'(viol_b[0]), 0);

        // OUT_DELAY=4: back-to-back reads give back-to-back toggles
        for (int i = 0; i < 3; i++) begin
            set_b[1] = ~set_b[1];
            tick(3);
        end
        check("od4_cnt_full", cnt_b(1), 3);
        for (int i = 0; i < 3; i++) begin
            read_b[1] = ~read_b[1];
            tick(1);
            check("od4_rd_cnt", cnt_b(1), 2 - i);
            check("od4_out_wait", 32'(out_b[1]), 0);
        end
        tick(1);
        check("od4_out_t1", 32'(out_b[1]), 1);
        tick(1);
        check("od4_out_t2", 32'(out_b[1]), 0);
        tick(1);
        check("od4_out_t3", 32'(out_b[1]), 1);
        check("od4_viol", 32'(viol_b[1]), 0);

        // Reset one edge after a read drops the in-flight toggle
        set_b[0] = ~set_b[0];
        tick(4);
        read_b[0] = ~read_b[0];
        tick(1);
        check("mf_cnt", cnt_b(0), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("mf_out_b", 32'(out_b), 0);
            tick(1);
        end
        check("mf_count_b", 32'(count_b), 0);
        check("mf_viol_a",  32'(viol_a),  0);
        check("mf_ovf_a",   32'(ovf_a),   0);
        check("mf_out_a",   32'(out_a),   0);
        check("mf_ready_b", 32'(ready_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dro_array.md
# dro_array

Clocked, parametrised array of destructive-readout (DRO) storage cells for SFQ behavioural co-simulation and VCD assertion testing. Each channel stores up to DEPTH set pulses, emits one output pulse per read while non-empty, and flags timing-window violations and overflow as sticky bits. Pulses are toggle-encoded: any transition on a line is one pulse. The block sits between testbench pulse generators and the VCD assertion flow as the multi-channel, multi-depth successor of the single-bit DRO cell.

## Interface
- CHANNELS, 4: number of independent DRO channels (≥1)
- DEPTH, 1: pulses storable per channel; 1 = classic DRO (≥1)
- OUT_DELAY, 2: read-to-output latency in clock edges (≥1)
- HOLD_CYCLES, 2: set/read separation window; 0 disables checking
- INIT_CYCLES, 8: edges after reset during which input pulses are ignored
- CW, derived: $clog2(DEPTH+1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; **synchronous, active-high**
- set  in  CHANNELS  toggle-encoded write pulses
- read  in  CHANNELS  toggle-encoded destructive-read pulses
- out  out  CHANNELS  toggle-encoded output pulses
- count  out  CHANNELS*CW  stored pulse count per channel; channel i at [i*CW +: CW]
- viol  out  CHANNELS  sticky hold-window violation
- ovf  out  CHANNELS  sticky set-while-full
- ready  out  1  high once the init window has elapsed

## Operation
- Reset (rst high at an edge): out=0, count=0, viol=0, ovf=0, ready=0, set/read history registers=0, delay line cleared, init counter=0. Reset mid-operation drops in-flight output toggles.
- Event detection: a set (read) event on channel i is detected at edge E when set[i] (read[i]) differs from its history register; the history register loads at every edge.
- Init: for INIT_CYCLES edges after reset, events are detected and history updates, but count, out, viol and ovf are unchanged. ready rises at the edge that ends the window and stays high.
- Per-channel state: count in 0..DEPTH.
  - Read, count>0: count−1; one output toggle scheduled.
  - Read, count=0: ignored, no output.
  - Set, count<DEPTH: count+1.
  - Set, count=DEPTH: count unchanged, ovf set.
  - Simultaneous set and read: read first, then set. count>0 gives count unchanged plus output toggle. count=0 gives count=1 and no output. Also counts as a violation when HOLD_CYCLES>0.
- Violation: a set event and a read event on the same channel whose edges differ by fewer than HOLD_CYCLES edges set viol[i], in either order. Both events are still processed.
- Channels are fully independent.

## Timing
- count, viol, ovf update at the detection edge E.
- out[i] toggles at edge E+OUT_DELAY−1. OUT_DELAY=1 means the same edge as the count update.
- Back-to-back reads on consecutive edges produce toggles on consecutive edges. The delay line is a shift register, never a single pending flag.
- Hold tracking uses per-channel saturating counters of edges since the last set and the last read. Both counters start saturated, so there is no false violation after init.
- Sticky flags clear only on rst.

## Structure
- dro_array_pkg: CW computation function, toggle-detect helper function, count-width typedef.
- Sub-module dro_cell holds one channel: history registers, count, hold counters, delay line, flags. It is instantiated CHANNELS times via generate. The top level holds the init counter, ready, and port packing.

## Test plan
- Defaults. After rst and 8 edges, toggle set[0] then read[0] 5 edges later: count[0] goes 1 then 0; out[0] toggles 1 edge after the read is detected; viol=0.
- Init gate. Toggle set[1] at edge 3 after reset: count[1] stays 0; ready rises at edge 8.
- DEPTH=3. Four sets 4 edges apart: count saturates at 3 and ovf=1. Then four reads: exactly three out toggles, count=0.
- Hold window, HOLD_CYCLES=2. Set then read on the next edge sets viol=1. With count=0, simultaneous set and read gives count=1, no out toggle, viol=1.
- OUT_DELAY=4. Reads on three consecutive edges with count=3 produce three out toggles on consecutive edges, 3 edges after each read.
- Reset mid-flight. Assert rst one edge after a read with OUT_DELAY=4: no out toggle ever appears, and all outputs return to 0.
